aes_key_expander: RTL

Parametrised AES key-schedule engine generating the full round-key set for AES-128, AES-192 and AES-256, one 32-bit word per clock, into an internal round-key store. The cipher datapath then reads any round key by index with one-cycle latency, reading forward for encryption and in reverse for decryption. It sits between the key-load interface and the round datapath, and replaces the fixed 128-bit, on-the-fly byte-serial generator.

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_sub_word.sv | 11 +
 rtl/aes_key_expander.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers for the key-schedule engine: S-box, SubWord, xtime and
// key-length decoding.
package aes_pkg;

    localparam logic [1:0] KLEN_128 = 2'd0;
    localparam logic [1:0] KLEN_192 = 2'd1;
    localparam logic [1:0] KLEN_256 = 2'd2;
    localparam logic [1:0] KLEN_BAD = 2'd3;

    // Forward S-box, element 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            KLEN_128: return 4'd4;
            KLEN_192: return 4'd6;
            KLEN_256: return 4'd8;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            KLEN_128: return 4'd10;
            KLEN_192: return 4'd12;
            KLEN_256: return 4'd14;
            default:  return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel forward S-box lookups on one 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] in_w,
    output logic [31:0] out_w
);

    assign out_w = sub_word(in_w);

endmodule

// File: rtl/aes_key_expander.sv
// AES-128/192/256 key schedule: one word per cycle into a round-key store,
// with a registered 128-bit read port indexed by round.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         key_err,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic [3:0]   num_rounds,
    input  logic [3:0]   rk_round,
    output logic [127:0] rk_out
);

    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam int AW    = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   nk_q, nk_d;
    logic [3:0]   nr_q, nr_d;
    logic         key_err_q, key_err_d;
    logic         done_q, done_d;
    logic         kv_q, kv_d;
    logic [127:0] rk_q, rk_d;
    logic [31:0]  win_q [MAX_NK];
    logic [31:0]  win_d [MAX_NK];
    logic [31:0]  store_q [DEPTH];

    logic         accept, len_ok, last;
    logic [31:0]  w_prev, w_old, sw_in, sw_out, temp, w_new;

    assign key_ready  = rst_n && (state_q != ST_EXPAND);
    assign busy       = (state_q == ST_EXPAND);
    assign key_err    = key_err_q;
    assign done       = done_q;
    assign keys_valid = kv_q;
    assign num_rounds = nr_q;
    assign rk_out     = rk_q;

    assign accept = key_valid && key_ready;
    assign len_ok = (key_len != KLEN_BAD) && (nk_of(key_len) <= 4'(MAX_NK));
    assign last   = (idx_q == {nr_q, 2'b11});

    // Window holds w[i-Nk] at slot 0 and w[i-1] at slot Nk-1.
    always_comb begin
        w_prev = win_q[0];
        for (int j = 0; j < MAX_NK; j++)
            if (4'(j) == nk_q - 4'd1) w_prev = win_q[j];
    end
    assign w_old = win_q[0];

    assign sw_in = (cnt_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_sub_word u_sub_word (
        .in_w  (sw_in),
        .out_w (sw_out)
    );

    always_comb begin
        if (cnt_q == 3'd0)
            temp = sw_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && cnt_q == 3'd4)
            temp = sw_out;
        else
            temp = w_prev;
    end
    assign w_new = w_old ^ temp;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rcon_d    = rcon_q;
        nk_d      = nk_q;
        nr_d      = nr_q;
        kv_d      = kv_q;
        key_err_d = 1'b0;
        done_d    = 1'b0;
        for (int j = 0; j < MAX_NK; j++) win_d[j] = win_q[j];

        case (state_q)
            ST_EXPAND: begin
                for (int j = 0; j < MAX_NK; j++) begin
                    if (4'(j) == nk_q - 4'd1)
                        win_d[j] = w_new;
                    else if (4'(j) < nk_q - 4'd1)
                        win_d[j] = win_q[(j + 1) % MAX_NK];
                end
                idx_d = idx_q + 6'd1;
                cnt_d = ({1'b0, cnt_q} == nk_q - 4'd1) ? 3'd0 : cnt_q + 3'd1;
                if (cnt_q == 3'd0) rcon_d = xtime(rcon_q);
                if (last) begin
                    state_d = ST_READY;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    if (len_ok) begin
                        state_d = ST_EXPAND;
                        nk_d    = nk_of(key_len);
                        nr_d    = nr_of(key_len);
                        kv_d    = 1'b0;
                        idx_d   = {2'b00, nk_of(key_len)};
                        cnt_d   = 3'd0;
                        rcon_d  = 8'h01;
                        for (int j = 0; j < MAX_NK; j++)
                            win_d[j] = key[255 - 32*j -: 32];
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        logic [5:0] ridx;
        rk_d = '0;
        for (int k = 0; k < 4; k++) begin
            ridx = {rk_round, 2'b00} + 6'(k);
            if (int'(ridx) < DEPTH)
                rk_d[127 - 32*k -: 32] = store_q[AW'(ridx)];
        end
    end

    // The store is never reset; the schedule is only trusted while keys_valid.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (accept && len_ok) begin
                for (int j = 0; j < MAX_NK; j++)
                    if (4'(j) < nk_of(key_len))
                        store_q[j] <= key[255 - 32*j -: 32];
            end else if (state_q == ST_EXPAND) begin
                store_q[AW'(idx_q)] <= w_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            rcon_q    <= 8'h01;
            nk_q      <= '0;
            nr_q      <= '0;
            kv_q      <= 1'b0;
            key_err_q <= 1'b0;
            done_q    <= 1'b0;
            rk_q      <= '0;
            for (int j = 0; j < MAX_NK; j++) win_q[j] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rcon_q    <= rcon_d;
            nk_q      <= nk_d;
            nr_q      <= nr_d;
            kv_q      <= kv_d;
            key_err_q <= key_err_d;
            done_q    <= done_d;
            rk_q      <= rk_d;
            for (int j = 0; j < MAX_NK; j++) win_q[j] <= win_d[j];
        end
    end

endmodule
